// File: rtl/gray_codec_pipe.sv
// Pipelined bidirectional Gray<->binary converter with valid/ready handshake
// and a one-bit-step check on consecutive Gray inputs.
// Latency: LATENCY cycles from accept to out_valid. Throughput is one beat per cycle.
// Backpressure: in_ready = !out_valid || out_ready. The whole pipe shifts or holds as one unit.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     input handshake; in_data operand, in_mode 0=G->B, 1=B->G
//   out_valid/out_ready   output handshake; out_data result, out_mode beat's mode
//   out_adj_err           beat was a Gray input not exactly 1 bit from the previous one
//   err_cnt               saturating count of error beats that have transferred out
module gray_codec_pipe #(
  parameter int WIDTH     = 8,
  parameter int LATENCY   = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_mode,
  output logic                 out_adj_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // Stage k holds a beat accepted k+1 cycles earlier (when not stalled).
  // The last stage drives the outputs directly.
  logic [LATENCY-1:0] stg_vld;
  logic [LATENCY-1:0] stg_mode;
  logic [LATENCY-1:0] stg_err;
  logic [WIDTH-1:0]   stg_dat [LATENCY];

  logic [WIDTH-1:0] prev_gray;
  logic             prev_valid;

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] conv_dat;
  logic [WIDTH-1:0] diff;
  logic             adj_err;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // Exactly one bit differs iff diff is non-zero and a power of two. A repeated
  // value (diff == 0) therefore counts as an error.
  always_comb begin
    conv_dat = in_mode ? (in_data ^ (in_data >> 1)) : gray2bin(in_data);
    diff     = in_data ^ prev_gray;
    adj_err  = !in_mode && prev_valid &&
               ((diff == '0) || ((diff & (diff - 1'b1)) != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld  <= '0;
      stg_mode <= '0;
      stg_err  <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        stg_dat[k] <= '0;
      end
    end else if (adv) begin
      // Bubbles shift like beats; stage 0 loads a bubble when nothing is accepted.
      stg_vld[0]  <= accept;
      stg_mode[0] <= in_mode;
      stg_err[0]  <= accept && adj_err;
      stg_dat[0]  <= conv_dat;
      for (int k = 1; k < LATENCY; k++) begin
        stg_vld[k]  <= stg_vld[k-1];
        stg_mode[k] <= stg_mode[k-1];
        stg_err[k]  <= stg_err[k-1];
        stg_dat[k]  <= stg_dat[k-1];
      end
    end
  end

  // Only mode-0 beats advance the Gray history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray  <= '0;
      prev_valid <= 1'b0;
    end else if (accept && !in_mode) begin
      prev_gray  <= in_data;
      prev_valid <= 1'b1;
    end
  end

  // Counted on transfer out, so a beat stalled at the output is counted once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_adj_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid   = stg_vld[LATENCY-1];
  assign out_mode    = stg_mode[LATENCY-1];
  assign out_adj_err = stg_err[LATENCY-1];
  assign out_data    = stg_dat[LATENCY-1];

endmodule
